// File: rtl/br_arb_fixed_aging.sv
// Fixed-priority arbiter with per-requester wait-age promotion and an optional grant lock.
// Grant is combinational from request and registered age/lock state.

module br_arb_fixed_aging_age #(
    parameter int MaxWait = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic gnt_i,
    output logic promoted_o
);
    localparam int AgeW = $clog2(MaxWait + 1);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(MaxWait);

    logic [AgeW-1:0] age_q, age_d;

    always_comb begin
        age_d = '0;
        if (req_i && !gnt_i) begin
            age_d = (age_q == AgeMax) ? AgeMax : age_q + AgeW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end

    assign promoted_o = req_i && (age_q == AgeMax);
endmodule

module br_arb_fixed_aging #(
    parameter int NumRequesters = 2,
    parameter int MaxWait       = 8,
    parameter bit EnableLock    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NumRequesters-1:0] request,
    input  logic                     lock,
    output logic [NumRequesters-1:0] grant,
    output logic [NumRequesters-1:0] promoted,
    output logic                     grant_locked
);
    localparam int IdxW = $clog2(NumRequesters);

    if (NumRequesters < 2) begin : g_bad_n
        $error("NumRequesters must be >= 2");
    end
    if (MaxWait < 1) begin : g_bad_wait
        $error("MaxWait must be >= 1");
    end

    logic            lock_valid_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_hit;

    function automatic logic [NumRequesters-1:0] lowest(input logic [NumRequesters-1:0] v);
        logic [NumRequesters-1:0] r;
        logic                     found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    for (genvar g = 0; g < NumRequesters; g++) begin : g_age
        br_arb_fixed_aging_age #(.MaxWait(MaxWait)) u_age (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_i      (request[g]),
            .gnt_i      (grant[g]),
            .promoted_o (promoted[g])
        );
    end

    assign lock_hit = lock_valid_q && request[lock_idx_q];

    // Lock beats promotion so a multi-cycle owner is never pre-empted mid-transaction.
    always_comb begin
        grant        = '0;
        grant_locked = 1'b0;
        if (lock_hit) begin
            grant[lock_idx_q] = 1'b1;
            grant_locked      = 1'b1;
        end else if (|promoted) begin
            grant = lowest(promoted);
        end else begin
            grant = lowest(request);
        end
    end

    if (EnableLock) begin : g_lock
        logic            lock_valid_d;
        logic [IdxW-1:0] lock_idx_d;

        always_comb begin
            lock_valid_d = lock && (|grant);
            lock_idx_d   = '0;
            for (int i = 0; i < NumRequesters; i++) begin
                if (grant[i]) lock_idx_d = IdxW'(i);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lock_valid_q <= 1'b0;
                lock_idx_q   <= '0;
            end else begin
                lock_valid_q <= lock_valid_d;
                lock_idx_q   <= lock_idx_d;
            end
        end
    end else begin : g_nolock
        assign lock_valid_q = 1'b0;
        assign lock_idx_q   = '0;

        a_lock_unused: assert property (@(posedge clk) disable iff (!rst_n) !lock)
            else $error("lock asserted with EnableLock = 0");
    end

    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant))
        else $error("grant not onehot0");
    a_subset: assert property (@(posedge clk) disable iff (!rst_n) (grant & ~request) == '0)
        else $error("grant outside request");
    a_work_conserving: assert property (@(posedge clk) disable iff (!rst_n) (|request) |-> (|grant))
        else $error("request pending with no grant");
    // Without a lock, a saturated requester must win this cycle; this bounds starvation.
    a_promote_wins: assert property (@(posedge clk) disable iff (!rst_n)
        ((|promoted) && !lock_hit) |-> (|(grant & promoted)))
        else $error("promoted requester not granted");
endmodule

// File: tb/tb_br_arb_fixed_aging.sv
// Directed bench: u_a (N=4, MaxWait=3) and u_b (N=4, MaxWait=2) share clk and rst_n.
module tb_br_arb_fixed_aging;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic       lock_a, lock_b;
    logic [3:0] gnt_a, gnt_b, prom_a, prom_b;
    logic       gl_a, gl_b;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    br_arb_fixed_aging #(.NumRequesters(4), .MaxWait(3), .EnableLock(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .request(req_a), .lock(lock_a),
        .grant(gnt_a), .promoted(prom_a), .grant_locked(gl_a));

    br_arb_fixed_aging #(.NumRequesters(4), .MaxWait(2), .EnableLock(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .request(req_b), .lock(lock_b),
        .grant(gnt_b), .promoted(prom_b), .grant_locked(gl_b));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 4'b1010; lock_a = 1'b0; req_b = 4'b0000; lock_b = 1'b0;
        #2;
        checks++;
        if (gnt_a !== 4'b0010) $display("FAIL reset_grant: got %b want 0010", gnt_a); else passes++;
        checks++;
        if (prom_a !== 4'b0000) $display("FAIL reset_promoted: got %b want 0000", prom_a); else passes++;
        checks++;
        if (gl_a !== 1'b0) $display("FAIL reset_locked: got %b want 0", gl_a); else passes++;
        next_cycle();
        rst_n = 1'b1; req_a = 4'b0000;
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001};
        req_a = 4'b0101; lock_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            checks++;
            if (gnt_a !== exp_g[c])
                $display("FAIL starve_grant c%0d: got %b want %b", c, gnt_a, exp_g[c]);
            else passes++;
            checks++;
            if (prom_a !== ((c == 3) ? 4'b0100 : 4'b0000))
                $display("FAIL starve_promoted c%0d: got %b want %b", c, prom_a,
                         (c == 3) ? 4'b0100 : 4'b0000);
            else passes++;
            next_cycle();
        end
        req_a = 4'b0000;
        next_cycle();
    endtask

    task automatic test_lock();
        logic [3:0] rq   [7] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
        logic       lk   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] eg   [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        logic       el   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] ep   [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        for (int c = 0; c < 7; c++) begin
            req_a = rq[c]; lock_a = lk[c];
            #2;
            checks++;
            if (gnt_a !== eg[c] || gl_a !== el[c])
                $display("FAIL lock_grant c%0d: got %b/%b want %b/%b", c, gnt_a, gl_a, eg[c], el[c]);
            else passes++;
            checks++;
            if (prom_a !== ep[c])
                $display("FAIL lock_promoted c%0d: got %b want %b", c, prom_a, ep[c]);
            else passes++;
            next_cycle();
        end
    endtask

    task automatic test_lock_drop();
        logic [3:0] rq [6] = '{4'b1000, 4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic       lk [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] eg [6] = '{4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic       el [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 6; c++) begin
            req_a = rq[c]; lock_a = lk[c];
            #2;
            checks++;
            if (gnt_a !== eg[c] || gl_a !== el[c])
                $display("FAIL lock_drop c%0d: got %b/%b want %b/%b", c, gnt_a, gl_a, eg[c], el[c]);
            else passes++;
            next_cycle();
        end
    endtask

    // Requester 1 idle so only 2 and 3 saturate behind the lock on requester 0.
    task automatic test_simul_promotion();
        logic       lk [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] eg [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
        logic       el [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] ep [6] = '{4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b1000, 4'b0001};
        req_b = 4'b1101;
        for (int c = 0; c < 6; c++) begin
            lock_b = lk[c];
            #2;
            checks++;
            if (gnt_b !== eg[c] || gl_b !== el[c])
                $display("FAIL simul_grant c%0d: got %b/%b want %b/%b", c, gnt_b, gl_b, eg[c], el[c]);
            else passes++;
            checks++;
            if (prom_b !== ep[c])
                $display("FAIL simul_promoted c%0d: got %b want %b", c, prom_b, ep[c]);
            else passes++;
            next_cycle();
        end
        req_b = 4'b0000; lock_b = 1'b0;
        next_cycle();
    endtask

    task automatic test_async_reset();
        req_a = 4'b0101; lock_a = 1'b0;
        for (int c = 0; c < 3; c++) next_cycle();
        #2;
        checks++;
        if (prom_a !== 4'b0100) $display("FAIL areset_pre_promoted: got %b want 0100", prom_a); else passes++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (prom_a !== 4'b0000) $display("FAIL areset_promoted: got %b want 0000", prom_a); else passes++;
        checks++;
        if (gnt_a !== 4'b0001 || gl_a !== 1'b0)
            $display("FAIL areset_grant: got %b/%b want 0001/0", gnt_a, gl_a);
        else passes++;
        next_cycle();
        rst_n = 1'b1; req_a = 4'b0110;
        #2;
        checks++;
        if (gnt_a !== 4'b0010) $display("FAIL areset_post_grant: got %b want 0010", gnt_a); else passes++;
        checks++;
        if (prom_a !== 4'b0000) $display("FAIL areset_post_promoted: got %b want 0000", prom_a); else passes++;
        next_cycle();
        req_a = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_lock();
        test_lock_drop();
        test_simul_promotion();
        test_async_reset();
        next_cycle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
